// File: rtl/sort_job_arbiter.sv
// Round-robin arbiter that runs one sort job at a time on a shared sorter.
// It sequences the sorter through reset, settle, start and wait, then returns the sorted block.
module sort_job_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int NREQ     = 2,
  parameter int SORT_LAT = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*N*W-1:0]       req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      srt_rst,
  output logic                      srt_start,
  output logic [N*W-1:0]            srt_data_in,
  input  logic [N*W-1:0]            srt_data_out,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [N*W-1:0]            rsp_data,
  input  logic                      rsp_ready,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(SORT_LAT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, START, WAIT, RESP} state_t;

  state_t          state_reg;
  logic [CW-1:0]   wait_cnt_reg;
  logic [IDW-1:0]  last_grant_reg;

  logic [N*W-1:0]  req_block [NREQ];
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign req_block[gi] = req_data[gi*N*W +: N*W];
  end

  // Search upward from the requester after last_grant; lowest offset wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last_grant_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_reg == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      srt_rst        <= 1'b1;
      srt_start      <= 1'b0;
      srt_data_in    <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_data       <= '0;
      busy           <= 1'b0;
      wait_cnt_reg   <= '0;
      last_grant_reg <= IDW'(NREQ - 1);
    end else begin
      srt_rst   <= 1'b0;
      srt_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            srt_data_in    <= req_block[grant_idx];
            rsp_id         <= grant_idx;
            last_grant_reg <= grant_idx;
            srt_rst        <= 1'b1;
            busy           <= 1'b1;
            state_reg      <= LOAD;
          end
        end
        LOAD: state_reg <= SETTLE;
        SETTLE: begin
          srt_start <= 1'b1;
          state_reg <= START;
        end
        START: begin
          wait_cnt_reg <= CW'(SORT_LAT - 1);
          state_reg    <= WAIT;
        end
        WAIT: begin
          // The sorter output is valid exactly in the last WAIT cycle.
          if (wait_cnt_reg == '0) begin
            rsp_data  <= srt_data_out;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Bench for sort_job_arbiter: behavioural sorter, cycle-count job model, directed and random stimulus.
module tb_sort_job_arbiter;
  localparam int N = 4, W = 8, NREQ = 2, L = 20;
  localparam int BW = N * W;
  localparam int RESP_T = L + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*BW-1:0] req_data = '0;
  logic [NREQ-1:0] req_ready;
  logic srt_rst, srt_start;
  logic [BW-1:0] srt_data_in, srt_data_out;
  logic rsp_valid;
  logic [0:0] rsp_id;
  logic [BW-1:0] rsp_data;
  logic rsp_ready = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  sort_job_arbiter #(.N(N), .W(W), .NREQ(NREQ), .SORT_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .srt_rst(srt_rst), .srt_start(srt_start),
    .srt_data_in(srt_data_in), .srt_data_out(srt_data_out), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  int checks = 0, passed = 0, cyc = 0;

  function automatic logic [BW-1:0] pack(input string s);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = s[i];
    return v;
  endfunction

  function automatic logic [BW-1:0] sort_block(input logic [BW-1:0] b);
    logic [W-1:0] a [N];
    logic [W-1:0] tmp;
    logic [BW-1:0] v;
    for (int i = 0; i < N; i++) a[i] = b[i*W +: W];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp; end
    for (int i = 0; i < N; i++) v[i*W +: W] = a[i];
    return v;
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Behavioural sorter: garbage until SORT_LAT cycles after the start pulse.
  int srt_cnt = 0;
  always @(posedge clk) begin
    if (srt_rst) srt_cnt <= 0;
    else if (srt_start) srt_cnt <= 1;
    else if (srt_cnt != 0 && srt_cnt < L) srt_cnt <= srt_cnt + 1;
  end
  assign srt_data_out = (srt_cnt == L) ? sort_block(srt_data_in) : 32'hA5A5A5A5;

  // Job model: elapsed cycles since grant determine every output.
  bit m_armed = 0, m_in_rst = 0, m_active = 0;
  int m_t = 0, m_last = NREQ - 1, m_id = 0, g;
  logic [BW-1:0] m_din = '0, m_dout = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_armed = 1; m_in_rst = 1; m_active = 0; m_t = 0;
      m_last = NREQ - 1; m_id = 0; m_din = '0; m_dout = '0;
    end else begin
      m_in_rst = 0;
      if (m_active) begin
        if (m_t >= RESP_T && rsp_ready) m_active = 0;
        else if (m_t < RESP_T) begin
          m_t++;
          if (m_t == RESP_T) m_dout = sort_block(m_din);
        end
      end else begin
        g = rr_pick(m_last, req_valid);
        if (g >= 0) begin
          m_active = 1; m_t = 1; m_id = g; m_last = g;
          m_din = req_data[g*BW +: BW];
        end
      end
    end
  end

  int g_id[$], g_cyc[$], r_id[$], r_cyc[$];
  logic [BW-1:0] r_data[$];
  int rst_cyc = -1, start_cyc = -1, eg;
  logic [NREQ-1:0] exp_ready;

  always @(negedge clk) begin
    if (m_armed) begin
      eg = rr_pick(m_last, req_valid);
      exp_ready = '0;
      if (rst_n && !m_active && eg >= 0) exp_ready[eg] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("srt_rst", srt_rst, m_in_rst || (m_active && m_t == 1));
      check("srt_start", srt_start, m_active && m_t == 3);
      check("busy", busy, m_active);
      check("rsp_valid", rsp_valid, m_active && m_t >= RESP_T);
      check("rsp_id", rsp_id, m_id);
      check("rsp_data", rsp_data, m_dout);
      check("srt_data_in", srt_data_in, m_din);
      for (int r = 0; r < NREQ; r++)
        if (req_ready[r]) begin
          g_id.push_back(r); g_cyc.push_back(cyc);
          $display("grant req=%0d cycle=%0d", r, cyc);
        end
      if (rsp_valid && rsp_ready) begin
        r_id.push_back(rsp_id); r_data.push_back(rsp_data); r_cyc.push_back(cyc);
        $display("resp id=%0d data=%h cycle=%0d", rsp_id, rsp_data, cyc);
      end
      if (srt_rst && busy) rst_cyc = cyc;
      if (srt_start) start_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n;
    n = 0;
    while (r_id.size() < target && n < budget) begin tick(); n++; end
    check("wait_resp count", r_id.size() >= target, 1);
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n;
    n = 0;
    while (g_id.size() < target && n < budget) begin tick(); n++; end
    check("wait_grant count", g_id.size() >= target, 1);
  endtask

  int g0, r0, n;

  initial begin
    rst_n = 0; rsp_ready = 1;
    repeat (3) tick();
    check("reset srt_rst", srt_rst, 1);
    check("reset busy", busy, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset srt_data_in", srt_data_in, 0);
    rst_n = 1; tick();
    check("idle srt_rst", srt_rst, 0);

    // Single job
    g0 = g_id.size(); r0 = r_id.size();
    req_data = {pack("xxxx"), pack("cadb")};
    req_valid = 2'b01; tick(); req_valid = 0;
    wait_resp(r0 + 1, 60);
    check("single id", r_id[r0], 0);
    check("single data", r_data[r0], pack("abcd"));
    check("single latency", r_cyc[r0] - g_cyc[g0], 24);
    check("single rst-start gap", start_cyc - rst_cyc, 2);
    check("single start after grant", start_cyc - g_cyc[g0], 3);

    // Round robin after a fresh reset
    rst_n = 0; tick(); rst_n = 1;
    g0 = g_id.size(); r0 = r_id.size();
    req_data = {pack("twoa"), pack("baba")};
    req_valid = 2'b11;
    wait_grants(g0 + 4, 200);
    req_valid = 0;
    wait_resp(r0 + 4, 100);
    for (int k = 0; k < 4; k++) begin
      check("rr grant order", g_id[g0+k], k % 2);
      check("rr resp id", r_id[r0+k], k % 2);
      check("rr resp data", r_data[r0+k], (k % 2) ? pack("aotw") : pack("aabb"));
    end

    // Backpressure, with requester 1 waiting meanwhile
    g0 = g_id.size(); r0 = r_id.size();
    req_data = {pack("twoa"), pack("dcba")};
    rsp_ready = 0; req_valid = 2'b01; tick(); req_valid = 2'b10;
    n = 0;
    while (!rsp_valid && n < 60) begin tick(); n++; end
    check("bp rsp_valid seen", rsp_valid, 1);
    repeat (10) begin
      check("bp hold valid", rsp_valid, 1);
      check("bp hold data", rsp_data, pack("abcd"));
      check("bp hold id", rsp_id, 0);
      tick();
    end
    check("bp no grant while held", g_id.size(), g0 + 1);
    rsp_ready = 1; tick();
    check("bp idle after transfer", busy, 0);
    tick(); req_valid = 0;
    check("bp next grant id", g_id[g0+1], 1);
    check("bp next grant timing", g_cyc[g0+1], r_cyc[r0] + 1);
    wait_resp(r0 + 2, 60);
    check("bp second data", r_data[r0+1], pack("aotw"));

    // Busy blocking: requester 1 raises valid during requester 0's WAIT
    g0 = g_id.size(); r0 = r_id.size();
    req_data = {pack("abca"), pack("hgfe")};
    req_valid = 2'b01; tick(); req_valid = 0;
    repeat (10) tick();
    req_valid = 2'b10;
    wait_grants(g0 + 2, 80);
    req_valid = 0;
    wait_resp(r0 + 2, 60);
    check("block first grant", g_id[g0], 0);
    check("block second grant", g_id[g0+1], 1);
    check("block grant after transfer", g_cyc[g0+1], r_cyc[r0] + 1);
    check("block data0", r_data[r0], pack("efgh"));
    check("block data1", r_data[r0+1], pack("aabc"));

    // Reset mid-WAIT aborts the job
    req_data = {pack("zyxw"), pack("dcba")};
    req_valid = 2'b01; tick(); req_valid = 0;
    repeat (10) tick();
    rst_n = 0; tick();
    check("abort srt_rst", srt_rst, 1);
    check("abort busy", busy, 0);
    check("abort srt_start", srt_start, 0);
    check("abort rsp_data", rsp_data, 0);
    check("abort srt_data_in", srt_data_in, 0);
    rst_n = 1;
    r0 = r_id.size();
    repeat (40) tick();
    check("abort no response", r_id.size(), r0);
    req_valid = 2'b10; tick(); req_valid = 0;
    wait_resp(r0 + 1, 60);
    check("after abort id", r_id[r0], 1);
    check("after abort data", r_data[r0], pack("wxyz"));

    // Withdrawn request while busy
    g0 = g_id.size(); r0 = r_id.size();
    req_data = {pack("hgfe"), pack("qqqq")};
    req_valid = 2'b10; tick(); req_valid = 0;
    repeat (5) tick();
    req_valid = 2'b01; tick(); req_valid = 0;
    wait_resp(r0 + 1, 60);
    repeat (30) tick();
    check("withdrawn grants", g_id.size(), g0 + 1);
    check("withdrawn responses", r_id.size(), r0 + 1);
    check("withdrawn resp data", r_data[r0], pack("efgh"));

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      req_valid = NREQ'($urandom_range(0, 3));
      req_data = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1; req_valid = 0; rsp_ready = 1;
    repeat (5) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
